// File: rtl/intc_pkg.sv
// Shared types and register map for the RAT interrupt controller.
package intc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } intc_state_t;

   localparam logic [1:0] OFS_MASK = 2'd0;
   localparam logic [1:0] OFS_PEND = 2'd1;
   localparam logic [1:0] OFS_ID   = 2'd2;
   localparam logic [1:0] OFS_STAT = 2'd3;

   localparam logic [7:0] ID_NONE = 8'h80;

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; combinational.
module intc_prio_enc #(
   parameter int N_SRC = 8
) (
   input  logic [N_SRC-1:0] req_i,
   output logic             valid_o,
   output logic [2:0]       idx_o
);

   always_comb begin
      valid_o = 1'b0;
      idx_o   = 3'd0;
      // Scan downward so the last hit written is the lowest index.
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            valid_o = 1'b1;
            idx_o   = 3'(i);
         end
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// RAT interrupt controller: edge-latched pending, mask, claim/ACK/EOI handshake on the port bus.
// Optional INTC_SYNC_EN adds a 2-flop synchronizer on each IRQ_IN bit before edge detect.
module intr_ctrl
   import intc_pkg::*;
#(
   parameter int         N_SRC     = 8,
   parameter logic [7:0] BASE_PORT = 8'hF0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [N_SRC-1:0] IRQ_IN,
   input  logic [7:0]       PORT_ID,
   input  logic [7:0]       OUT_PORT,
   input  logic             IO_STRB,
   output logic             INTR,
   output logic [7:0]       RD_DATA,
   output logic             RD_HIT
);

   logic [N_SRC-1:0] irq_s, irq_q, edge_s;
   logic [N_SRC-1:0] mask_q, mask_d, pend_q, pend_d;
   logic [N_SRC-1:0] w1c_clr, ack_clr;
   logic [7:0]       mask8, pend8, pm8, ack_clr8, ofs;
   logic             wr, wr_mask, wr_pend, wr_ack, wr_eoi, ack_ok;
   logic             enc_valid;
   logic [2:0]       enc_idx, isr_id_q;
   logic             intr_q;
   intc_state_t      state_q;

`ifdef INTC_SYNC_EN
   logic [N_SRC-1:0] sync1_q, sync2_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= IRQ_IN;
         sync2_q <= sync1_q;
      end
   end
   assign irq_s = sync2_q;
`else
   assign irq_s = IRQ_IN;
`endif

   // Tracks the line through reset so a level held high is not seen as a new edge.
   always_ff @(posedge CLK) begin
      irq_q <= irq_s;
   end
   assign edge_s = irq_s & ~irq_q;

   assign ofs     = PORT_ID - BASE_PORT;
   assign RD_HIT  = (ofs < 8'd4);
   assign wr      = IO_STRB & RD_HIT;
   assign wr_mask = wr & (ofs[1:0] == OFS_MASK);
   assign wr_pend = wr & (ofs[1:0] == OFS_PEND);
   assign wr_ack  = wr & (ofs[1:0] == OFS_ID);
   assign wr_eoi  = wr & (ofs[1:0] == OFS_STAT);

   assign mask8 = 8'(mask_q);
   assign pend8 = 8'(pend_q);
   assign pm8   = pend8 & mask8;

   intc_prio_enc #(.N_SRC(N_SRC)) u_prio (
      .req_i   (pend_q & mask_q),
      .valid_o (enc_valid),
      .idx_o   (enc_idx)
   );

   assign ack_ok   = wr_ack && (state_q == ASSERT) && enc_valid && pm8[OUT_PORT[2:0]];
   assign ack_clr8 = ack_ok ? (8'd1 << OUT_PORT[2:0]) : 8'd0;
   assign ack_clr  = ack_clr8[N_SRC-1:0];
   assign w1c_clr  = wr_pend ? OUT_PORT[N_SRC-1:0] : '0;

   // A same-cycle edge re-sets the bit after any clear.
   assign pend_d = (pend_q & ~w1c_clr & ~ack_clr) | edge_s;
   assign mask_d = wr_mask ? OUT_PORT[N_SRC-1:0] : mask_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         mask_q <= '0;
         pend_q <= '0;
      end else begin
         mask_q <= mask_d;
         pend_q <= pend_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         intr_q   <= 1'b0;
         isr_id_q <= 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|(pend_q & mask_q)) begin
                  state_q <= ASSERT;
                  intr_q  <= 1'b1;
               end
            end
            ASSERT: begin
               if (ack_ok) begin
                  state_q  <= SERVICE;
                  intr_q   <= 1'b0;
                  isr_id_q <= OUT_PORT[2:0];
               end else if (!(|(pend_d & mask_d))) begin
                  state_q <= IDLE;
                  intr_q  <= 1'b0;
               end
            end
            SERVICE: begin
               if (wr_eoi) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               intr_q  <= 1'b0;
            end
         endcase
      end
   end

   assign INTR = intr_q;

   always_comb begin
      RD_DATA = 8'h00;
      if (RD_HIT) begin
         case (ofs[1:0])
            OFS_MASK: RD_DATA = mask8;
            OFS_PEND: RD_DATA = pend8;
            OFS_ID:   RD_DATA = enc_valid ? {5'b0, enc_idx} : ID_NONE;
            default:  RD_DATA = {state_q, 3'b000, isr_id_q};
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: stimulus pushes expected reads into a scoreboard, a negedge monitor compares.
module tb_intr_ctrl;

   localparam logic [7:0] P_MASK = 8'hF0;
   localparam logic [7:0] P_PEND = 8'hF1;
   localparam logic [7:0] P_ID   = 8'hF2;
   localparam logic [7:0] P_STAT = 8'hF3;

   logic       clk;
   logic       reset;
   logic [7:0] irq_in;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       io_strb;
   logic       intr;
   logic [7:0] rd_data;
   logic       rd_hit;

   typedef struct packed {
      logic [7:0] rd;
      logic       hit;
      logic       intr;
   } exp_t;

   exp_t  sb_q[$];
   string nm_q[$];
   logic  chk_vld;
   int    n_vec;
   int    n_err;

   intr_ctrl #(.N_SRC(8), .BASE_PORT(8'hF0)) dut (
      .CLK      (clk),
      .RESET    (reset),
      .IRQ_IN   (irq_in),
      .PORT_ID  (port_id),
      .OUT_PORT (out_port),
      .IO_STRB  (io_strb),
      .INTR     (intr),
      .RD_DATA  (rd_data),
      .RD_HIT   (rd_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end
   endtask

   // Monitor: pops one expectation whenever the stimulus presents a read.
   always @(negedge clk) begin
      if (chk_vld) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: read presented with no expectation queued");
         end else begin
            exp_t  e;
            string nm;
            e  = sb_q.pop_front();
            nm = nm_q.pop_front();
            cmp({nm, ".rd"},   rd_data,         e.rd);
            cmp({nm, ".hit"},  {7'b0, rd_hit},  {7'b0, e.hit});
            cmp({nm, ".intr"}, {7'b0, intr},    {7'b0, e.intr});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      port_id  = addr;
      out_port = data;
      io_strb  = 1'b1;
      tick();
      io_strb  = 1'b0;
      port_id  = 8'h00;
      out_port = 8'h00;
   endtask

   task automatic check(input string nm, input logic [7:0] addr, input logic [7:0] exp_rd,
                        input logic exp_hit, input logic exp_intr);
      exp_t e;
      port_id = addr;
      e.rd    = exp_rd;
      e.hit   = exp_hit;
      e.intr  = exp_intr;
      sb_q.push_back(e);
      nm_q.push_back(nm);
      chk_vld = 1'b1;
      @(negedge clk);
      #1;
      chk_vld = 1'b0;
      port_id = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec    = 0;
      n_err    = 0;
      chk_vld  = 1'b0;
      reset    = 1'b1;
      irq_in   = 8'h00;
      port_id  = 8'h00;
      out_port = 8'h00;
      io_strb  = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("rst_mask", P_MASK, 8'h00, 1'b1, 1'b0);
      check("rst_pend", P_PEND, 8'h00, 1'b1, 1'b0);
      check("rst_id",   P_ID,   8'h80, 1'b1, 1'b0);
      check("rst_stat", P_STAT, 8'h00, 1'b1, 1'b0);
      check("no_hit",   8'h10,  8'h00, 1'b0, 1'b0);
      check("no_hit_hi",8'hF4,  8'h00, 1'b0, 1'b0);

      // Single source, latency and handshake
      wr(P_MASK, 8'h05);
      irq_in = 8'h04;
      tick();
      check("t1_pend", P_PEND, 8'h04, 1'b1, 1'b0);
      irq_in = 8'h00;
      tick();
      check("t1_id",   P_ID,   8'h02, 1'b1, 1'b1);
      check("t1_stat", P_STAT, 8'h40, 1'b1, 1'b1);
      wr(P_ID, 8'h02);
      check("t1_svc",  P_STAT, 8'h82, 1'b1, 1'b0);
      check("t1_pclr", P_PEND, 8'h00, 1'b1, 1'b0);
      wr(P_STAT, 8'h00);
      check("t1_eoi",  P_STAT, 8'h02, 1'b1, 1'b0);
      tick();
      check("t1_quiet",P_STAT, 8'h02, 1'b1, 1'b0);

      // Two sources, priority and re-assert after EOI
      wr(P_MASK, 8'hFF);
      irq_in = 8'h05;
      tick();
      irq_in = 8'h00;
      tick();
      check("t2_id0",  P_ID,   8'h00, 1'b1, 1'b1);
      wr(P_ID, 8'h00);
      check("t2_svc",  P_STAT, 8'h80, 1'b1, 1'b0);
      check("t2_pend", P_PEND, 8'h04, 1'b1, 1'b0);
      wr(P_STAT, 8'h00);
      check("t2_eoi",  P_STAT, 8'h00, 1'b1, 1'b0);
      tick();
      check("t2_id2",  P_ID,   8'h02, 1'b1, 1'b1);
      wr(P_ID, 8'h02);
      wr(P_STAT, 8'h00);
      check("t2_done", P_PEND, 8'h00, 1'b1, 1'b0);

      // Masked source, late unmask, W1C back to idle
      wr(P_MASK, 8'h00);
      irq_in = 8'h08;
      tick();
      irq_in = 8'h00;
      tick();
      check("t3_pend", P_PEND, 8'h08, 1'b1, 1'b0);
      tick();
      check("t3_idle", P_STAT, 8'h02, 1'b1, 1'b0);
      wr(P_MASK, 8'h08);
      check("t3_mask", P_MASK, 8'h08, 1'b1, 1'b0);
      tick();
      check("t3_asrt", P_STAT, 8'h42, 1'b1, 1'b1);
      wr(P_PEND, 8'h08);
      check("t3_w1c",  P_STAT, 8'h02, 1'b1, 1'b0);
      check("t3_pclr", P_PEND, 8'h00, 1'b1, 1'b0);

      // Ignored ACK of non-pending source, ignored EOI in ASSERT
      wr(P_MASK, 8'hFF);
      irq_in = 8'h02;
      tick();
      irq_in = 8'h00;
      tick();
      check("t4_asrt", P_STAT, 8'h42, 1'b1, 1'b1);
      wr(P_ID, 8'h05);
      check("t4_ack5", P_STAT, 8'h42, 1'b1, 1'b1);
      check("t4_pend", P_PEND, 8'h02, 1'b1, 1'b1);
      wr(P_STAT, 8'h00);
      check("t4_eoi",  P_STAT, 8'h42, 1'b1, 1'b1);
      wr(P_ID, 8'h01);
      check("t4_svc",  P_STAT, 8'h81, 1'b1, 1'b0);
      wr(P_STAT, 8'h00);
      check("t4_idle", P_STAT, 8'h01, 1'b1, 1'b0);

      // ACK colliding with a new edge on the same bit
      irq_in = 8'h10;
      tick();
      irq_in = 8'h00;
      tick();
      check("t5_id",   P_ID,   8'h04, 1'b1, 1'b1);
      irq_in = 8'h10;
      wr(P_ID, 8'h04);
      check("t5_stat", P_STAT, 8'h84, 1'b1, 1'b0);
      check("t5_pend", P_PEND, 8'h10, 1'b1, 1'b0);
      irq_in = 8'h00;
      wr(P_STAT, 8'h00);
      check("t5_eoi",  P_STAT, 8'h04, 1'b1, 1'b0);
      tick();
      check("t5_rea",  P_STAT, 8'h44, 1'b1, 1'b1);

      // Reset mid-service with lines held high
      wr(P_ID, 8'h04);
      check("t6_svc",  P_STAT, 8'h84, 1'b1, 1'b0);
      irq_in = 8'hFF;
      reset  = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      check("t6_mask", P_MASK, 8'h00, 1'b1, 1'b0);
      check("t6_pend", P_PEND, 8'h00, 1'b1, 1'b0);
      check("t6_stat", P_STAT, 8'h00, 1'b1, 1'b0);
      check("t6_id",   P_ID,   8'h80, 1'b1, 1'b0);
      irq_in = 8'h00;
      tick();

      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Multi-source interrupt controller for the RAT computer. It collects up to eight peripheral interrupt lines, latches rising edges as pending, applies a software mask and drives the CPU's single `INTERRUPTC` input through a claim/acknowledge/end-of-interrupt handshake. The ISR configures and services it over the existing port bus (`PORT_ID`, `OUT_PORT`, `IO_STRB`). Its read data feeds the top-level `IN_PORT` mux.

## Interface
Parameters:
- `N_SRC`, 8: number of interrupt sources, 1..8.
- `BASE_PORT`, 8'hF0: first of four consecutive port IDs owned by the block.

Ports:
- `CLK` in 1: system clock, rising edge.
- `RESET` in 1: reset, synchronous, active-high.
- `IRQ_IN` in N_SRC: peripheral interrupt lines, rising-edge sensitive.
- `PORT_ID` in 8: CPU port address.
- `OUT_PORT` in 8: CPU write data.
- `IO_STRB` in 1: CPU write strobe, one cycle per OUT instruction.
- `INTR` out 1: interrupt request to the CPU `INTERRUPTC` input.
- `RD_DATA` out 8: combinational read data for the addressed register, 0 when there is no hit.
- `RD_HIT` out 1: `PORT_ID` lies in BASE_PORT..BASE_PORT+3. The top-level uses it to select `RD_DATA` onto `IN_PORT`.

## Operation
Register map (offset from BASE_PORT):
- +0 MASK: R/W. Bit i=1 enables source i.
- +1 PEND: read returns the pending bits. A write is write-1-to-clear.
- +2 ID: read returns the highest-priority enabled pending source as {5'b0, idx[2:0]}, or 8'h80 if there is none. A write is an ACK of source `OUT_PORT[2:0]`.
- +3 STAT: read returns {state[1:0], 3'b0, isr_id[2:0]}. Any write is an EOI.

Sources:
- Priority is fixed: source 0 is highest.
- Bits at or above N_SRC read 0 and ignore writes.
- Edge detect: `irq_q <= IRQ_IN` every cycle, including during RESET, so no spurious edge is seen after reset.
- `pend[i]` is set in any cycle where `IRQ_IN[i] & ~irq_q[i]`.

FSM (state encoding IDLE=0, ASSERT=1, SERVICE=2):
- IDLE: go to ASSERT when `|(pend & mask)` is true.
- ASSERT: `INTR`=1.
  - An ACK whose idx has `pend[idx] & mask[idx]` set clears `pend[idx]`, loads `isr_id`=idx and moves to SERVICE.
  - An ACK of a non-pending or masked idx is ignored.
  - If `pend & mask` becomes 0 (mask write or W1C), return to IDLE.
- SERVICE: `INTR`=0. An EOI returns to IDLE. Other edges keep accumulating in `pend`.
- ACK outside ASSERT is ignored. EOI outside SERVICE is ignored.

Boundary rules:
- Same-cycle edge and W1C/ACK on the same bit: the set wins, so `pend` stays 1. An ACK under this rule still moves to SERVICE.
- A repeat edge while a source is already pending is merged (no count).
- Reads have no side effects, because the RAT has no read strobe.

## Timing
- Reset values: `INTR`=0, state IDLE, mask=0, pend=0, isr_id=0. `RD_DATA` and `RD_HIT` follow `PORT_ID` combinationally.
- `IRQ_IN` rises before edge k: `pend` is set at edge k, the state reaches ASSERT and `INTR`=1 at edge k+1.
- Registered writes take effect at the edge where `IO_STRB`=1 and `PORT_ID` matches.
- After an ACK at edge k: `INTR`=0 from edge k onward.
- After an EOI at edge k: IDLE at k. If anything is still pending and enabled, `INTR` re-asserts at k+1.
- RESET mid-handshake: all state is cleared at that edge. Pending events are lost.

## Configuration
- `INTC_SYNC_EN` defined: each `IRQ_IN` bit passes through a 2-flop synchronizer before edge detect. `INTR` latency becomes k+3, and synchronizer flops reset to 0.
- `INTC_SYNC_EN` undefined: `IRQ_IN` is assumed synchronous to `CLK`. Only `irq_q` is present, giving the latency stated above.

## Structure
- `intc_pkg`:
  - state enum `intc_state_t` (IDLE, ASSERT, SERVICE);
  - offset localparams `OFS_MASK`, `OFS_PEND`, `OFS_ID`, `OFS_STAT`;
  - `ID_NONE`=8'h80.
- Sub-module `intc_prio_enc`: combinational, `N_SRC` wide, produces `valid` and `idx[2:0]` with lowest index winning. It is used for the ID read and the ACK check.

## Test plan
- Reset, then MASK=8'h05, pulse `IRQ_IN[2]` -> `INTR`=1 two edges later, ID read = 8'h02, PEND = 8'h04.
- `IRQ_IN[0]` and `IRQ_IN[2]` rise together, mask 8'hFF -> ID = 8'h00. ACK 0 -> SERVICE, `INTR`=0. EOI -> `INTR`=1 again with ID = 8'h02.
- `IRQ_IN[3]` with MASK=0 -> PEND = 8'h08, `INTR` stays 0. Write MASK=8'h08 -> `INTR`=1 next edge. W1C PEND 8'h08 -> IDLE, `INTR`=0.
- In ASSERT with source 1 pending: ACK 5 -> ignored, state stays ASSERT. EOI -> ignored.
- ACK 4 in the same cycle as a new `IRQ_IN[4]` edge -> STAT = 8'h84 (SERVICE, isr_id 4), PEND bit 4 still 1.
- RESET asserted in SERVICE with `IRQ_IN` held high through reset -> all zero, and no pending bit set after release.
